// File: rtl/multi_edge_dect_if.sv
// multi_edge_dect_if: channel inputs, edge pulses and event status of the edge detector
interface multi_edge_dect_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0]       d_in;
  logic [WIDTH-1:0]       rise_en;
  logic [WIDTH-1:0]       fall_en;
  logic [WIDTH-1:0]       clr;
  logic [WIDTH-1:0]       rise_edge;
  logic [WIDTH-1:0]       fall_edge;
  logic [WIDTH-1:0]       level;
  logic [WIDTH-1:0]       evt_sticky;
  logic [WIDTH*CNT_W-1:0] evt_cnt;
  logic                   irq;
  modport master (
    output d_in, rise_en, fall_en, clr,
    input  rise_edge, fall_edge, level, evt_sticky, evt_cnt, irq
  );
  modport slave (
    input  d_in, rise_en, fall_en, clr,
    output rise_edge, fall_edge, level, evt_sticky, evt_cnt, irq
  );
endinterface

// File: rtl/multi_edge_dect.sv
// multi_edge_dect: per-channel synchroniser, glitch filter, edge pulses, sticky flags and saturating counters
module multi_edge_dect #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input logic              clk,
  input logic              rst,
  multi_edge_dect_if.slave bus
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_level, w_rise, w_fall, w_evt;
    logic                   r_level_d, r_rise, r_fall, r_sticky;
    logic [CNT_W-1:0]       r_cnt;
    always_ff @(posedge clk or posedge rst)
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], bus.d_in[i]};
    if (FILT_CYCLES == 0) begin : g_nof
      assign w_level = r_sync[SYNC_STAGES-1];
    end else begin : g_flt
      localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
      logic          r_level;
      logic [FW-1:0] r_flt;
      // r_flt counts prior differing samples; the FILT_CYCLES-th one flips level
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          r_level <= 1'b0;
          r_flt   <= '0;
        end else if (r_sync[SYNC_STAGES-1] == r_level) begin
          r_flt   <= '0;
        end else if (r_flt == FW'(FILT_CYCLES - 1)) begin
          r_level <= r_sync[SYNC_STAGES-1];
          r_flt   <= '0;
        end else begin
          r_flt   <= r_flt + FW'(1);
        end
      assign w_level = r_level;
    end
    assign w_rise = w_level & ~r_level_d;
    assign w_fall = ~w_level & r_level_d;
    assign w_evt  = (w_rise & bus.rise_en[i]) | (w_fall & bus.fall_en[i]);
    // a qualifying event beats a simultaneous clear, restarting the count at 1
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_level_d <= 1'b0;
        r_rise    <= 1'b0;
        r_fall    <= 1'b0;
        r_sticky  <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_level_d <= w_level;
        r_rise    <= w_rise;
        r_fall    <= w_fall;
        r_sticky  <= w_evt | (r_sticky & ~bus.clr[i]);
        r_cnt     <= w_evt ? (bus.clr[i] ? CNT_W'(1) : r_cnt + CNT_W'(r_cnt != CMAX))
                           : (bus.clr[i] ? '0 : r_cnt);
      end
    assign bus.level[i]                  = w_level;
    assign bus.rise_edge[i]              = r_rise;
    assign bus.fall_edge[i]              = r_fall;
    assign bus.evt_sticky[i]             = r_sticky;
    assign bus.evt_cnt[i*CNT_W +: CNT_W] = r_cnt;
  end
  assign bus.irq = |bus.evt_sticky;
endmodule

// File: tb/tb_multi_edge_dect.sv
// tb_multi_edge_dect: directed and random stimulus on two configurations, checked against a behavioural model
module tb_multi_edge_dect;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_edge_dect_if #(.WIDTH(4), .CNT_W(2)) ia ();
  multi_edge_dect_if #(.WIDTH(2), .CNT_W(3)) ib ();

  multi_edge_dect #(.WIDTH(4), .SYNC_STAGES(2), .FILT_CYCLES(3), .CNT_W(2))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  multi_edge_dect #(.WIDTH(2), .SYNC_STAGES(3), .FILT_CYCLES(0), .CNT_W(3))
    dut_b (.clk(clk), .rst(rst), .bus(ib));

  int n_chk = 0;
  int n_bad = 0;
  int wd [2] = '{4, 2};
  int ss [2] = '{2, 3};
  int fc [2] = '{3, 0};
  int cw [2] = '{2, 3};

  // model state: level, run of differing samples, pending edge, visible pulse, flag, count
  int m_lvl [2][4];
  int m_run [2][4];
  int m_pr  [2][4];
  int m_pf  [2][4];
  int m_r   [2][4];
  int m_f   [2][4];
  int m_st  [2][4];
  int m_cnt [2][4];
  logic [3:0] m_hist [2][8];

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        m_lvl[d][c] = 0; m_run[d][c] = 0; m_pr[d][c] = 0; m_pf[d][c] = 0;
        m_r[d][c] = 0; m_f[d][c] = 0; m_st[d][c] = 0; m_cnt[d][c] = 0;
      end
      for (int j = 0; j < 8; j++) m_hist[d][j] = '0;
    end
  endtask

  task automatic model_step(int d);
    logic [3:0] din, ren, fen, cl;
    int old [4];
    int evt, mx, s_old;
    if (rst) return;
    din = (d == 0) ? ia.d_in    : 4'(ib.d_in);
    ren = (d == 0) ? ia.rise_en : 4'(ib.rise_en);
    fen = (d == 0) ? ia.fall_en : 4'(ib.fall_en);
    cl  = (d == 0) ? ia.clr     : 4'(ib.clr);
    mx  = (1 << cw[d]) - 1;
    for (int c = 0; c < wd[d]; c++) begin
      m_r[d][c] = m_pr[d][c];
      m_f[d][c] = m_pf[d][c];
      evt = (m_r[d][c] & int'(ren[c])) | (m_f[d][c] & int'(fen[c]));
      if (evt != 0) begin
        m_st[d][c]  = 1;
        m_cnt[d][c] = cl[c] ? 1 : (m_cnt[d][c] < mx ? m_cnt[d][c] + 1 : mx);
      end else if (cl[c]) begin
        m_st[d][c]  = 0;
        m_cnt[d][c] = 0;
      end
      old[c] = m_lvl[d][c];
      s_old  = int'(m_hist[d][ss[d]-1][c]);
      if (fc[d] != 0) begin
        if (s_old != m_lvl[d][c]) begin
          m_run[d][c]++;
          if (m_run[d][c] == fc[d]) begin
            m_lvl[d][c] = s_old;
            m_run[d][c] = 0;
          end
        end else m_run[d][c] = 0;
      end
    end
    for (int j = 7; j > 0; j--) m_hist[d][j] = m_hist[d][j-1];
    m_hist[d][0] = din;
    for (int c = 0; c < wd[d]; c++) begin
      if (fc[d] == 0) m_lvl[d][c] = int'(m_hist[d][ss[d]-1][c]);
      m_pr[d][c] = (m_lvl[d][c] == 1 && old[c] == 0) ? 1 : 0;
      m_pf[d][c] = (m_lvl[d][c] == 0 && old[c] == 1) ? 1 : 0;
    end
  endtask

  task automatic compare(int d);
    logic [3:0]  r, f, l, s;
    logic [11:0] cv;
    int q, any;
    r  = (d == 0) ? ia.rise_edge  : 4'(ib.rise_edge);
    f  = (d == 0) ? ia.fall_edge  : 4'(ib.fall_edge);
    l  = (d == 0) ? ia.level      : 4'(ib.level);
    s  = (d == 0) ? ia.evt_sticky : 4'(ib.evt_sticky);
    cv = (d == 0) ? 12'(ia.evt_cnt) : 12'(ib.evt_cnt);
    q  = (d == 0) ? int'(ia.irq)  : int'(ib.irq);
    any = 0;
    for (int c = 0; c < wd[d]; c++) begin
      chk($sformatf("d%0d_rise%0d", d, c), int'(r[c]), m_r[d][c]);
      chk($sformatf("d%0d_fall%0d", d, c), int'(f[c]), m_f[d][c]);
      chk($sformatf("d%0d_level%0d", d, c), int'(l[c]), m_lvl[d][c]);
      chk($sformatf("d%0d_sticky%0d", d, c), int'(s[c]), m_st[d][c]);
      chk($sformatf("d%0d_cnt%0d", d, c), int'((cv >> (c * cw[d])) & ((12'd1 << cw[d]) - 12'd1)),
          m_cnt[d][c]);
      any |= m_st[d][c];
    end
    chk($sformatf("d%0d_irq", d), q, any);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare(0);
    compare(1);
  endtask

  task automatic enter_reset();
    rst = 1'b1;
    model_reset();
    #1;
    compare(0);
    compare(1);
  endtask

  // counts pulses on channel c of dut_a over n ticks and records when the first rise appears
  task automatic watch_a(int c, int n, output int nr, output int nf, output int first);
    nr = 0; nf = 0; first = -1;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (ia.rise_edge[c]) begin
        nr++;
        if (first < 0) first = k;
      end
      if (ia.fall_edge[c]) nf++;
    end
  endtask

  initial begin
    int nr, nf, first, ok;
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
    ia.d_in = '0; ia.rise_en = '1; ia.fall_en = '1; ia.clr = '0;
    ib.d_in = '0; ib.rise_en = '1; ib.fall_en = '1; ib.clr = '0;
    @(negedge clk);
    enter_reset();
    repeat (2) tick();
    rst = 1'b0;
    // single rise on channel 0
    ia.d_in[0] = 1'b1;
    watch_a(0, 10, nr, nf, first);
    chk("t1_rises", nr, 1);
    chk("t1_latency", first, 6);
    chk("t1_level", int'(ia.level[0]), 1);
    chk("t1_cnt", int'(ia.evt_cnt[1:0]), 1);
    chk("t1_irq", int'(ia.irq), 1);
    // two-cycle glitch rejected, three-cycle pulse accepted
    ia.d_in[1] = 1'b1; tick(); tick(); ia.d_in[1] = 1'b0;
    watch_a(1, 14, nr, nf, first);
    chk("t2_glitch_rise", nr, 0);
    chk("t2_glitch_fall", nf, 0);
    chk("t2_glitch_cnt", int'(ia.evt_cnt[3:2]), 0);
    ia.d_in[1] = 1'b1; tick(); tick(); tick(); ia.d_in[1] = 1'b0;
    watch_a(1, 16, nr, nf, first);
    chk("t2_pulse_rise", nr, 1);
    chk("t2_pulse_fall", nf, 1);
    // fall-only counting on channel 2
    ia.rise_en[2] = 1'b0;
    ia.d_in[2] = 1'b1;
    watch_a(2, 9, nr, nf, first);
    ia.d_in[2] = 1'b0;
    watch_a(2, 10, ok, nf, first);
    chk("t3_rise", nr, 1);
    chk("t3_fall", nf, 1);
    chk("t3_cnt", int'(ia.evt_cnt[5:4]), 1);
    chk("t3_sticky", int'(ia.evt_sticky[2]), 1);
    ia.rise_en[2] = 1'b1;
    // saturation of the 2-bit counter on channel 3
    for (int e = 0; e < 5; e++) begin
      ia.d_in[3] = ~ia.d_in[3];
      ok = 0;
      for (int k = 0; k < 20 && ok == 0; k++) begin
        tick();
        if (ia.rise_edge[3] | ia.fall_edge[3]) ok = 1;
      end
      chk($sformatf("t4_edge_seen%0d", e), ok, 1);
      chk($sformatf("t4_cnt%0d", e), int'(ia.evt_cnt[7:6]), exp_cnt[e]);
      repeat (2) tick();
    end
    ia.d_in[3] = ~ia.d_in[3];
    ok = 0;
    for (int k = 0; k < 20 && ok == 0; k++) begin
      if ((m_pr[0][3] | m_pf[0][3]) != 0) ok = 1;
      else tick();
    end
    chk("t4_edge_pending", ok, 1);
    ia.clr[3] = 1'b1; tick(); ia.clr[3] = 1'b0;
    chk("t4_clr_evt_cnt", int'(ia.evt_cnt[7:6]), 1);
    chk("t4_clr_evt_sticky", int'(ia.evt_sticky[3]), 1);
    ia.clr = '1; tick(); ia.clr = '0;
    chk("t4_clr_cnt", int'(ia.evt_cnt[7:6]), 0);
    chk("t4_clr_sticky", int'(ia.evt_sticky[3]), 0);
    chk("t4_clr_irq", int'(ia.irq), 0);
    // reset in the middle of a filter count
    ia.d_in = '0;
    repeat (12) tick();
    ia.d_in = '1;
    repeat (3) tick();
    enter_reset();
    chk("t5_rst_level", int'(ia.level), 0);
    chk("t5_rst_irq", int'(ia.irq), 0);
    repeat (2) tick();
    rst = 1'b0;
    watch_a(0, 10, nr, nf, first);
    chk("t5_rises", nr, 1);
    chk("t5_latency", first, 6);
    // unfiltered, three-stage configuration
    ib.d_in[0] = 1'b1; tick(); ib.d_in[0] = 1'b0;
    nr = 0; nf = 0; first = -1;
    for (int k = 2; k <= 9; k++) begin
      tick();
      if (ib.rise_edge[0]) begin nr++; if (first < 0) first = k; end
      if (ib.fall_edge[0]) nf++;
    end
    chk("t6_rise", nr, 1);
    chk("t6_fall", nf, 1);
    chk("t6_latency", first, 4);
    // random traffic on both configurations
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 4; c++) if ($urandom_range(0, 5) == 0) ia.d_in[c] = ~ia.d_in[c];
      for (int c = 0; c < 2; c++) if ($urandom_range(0, 3) == 0) ib.d_in[c] = ~ib.d_in[c];
      if ($urandom_range(0, 49) == 0) begin
        ia.rise_en = 4'($urandom); ia.fall_en = 4'($urandom);
        ib.rise_en = 2'($urandom); ib.fall_en = 2'($urandom);
      end
      ia.clr = ($urandom_range(0, 29) == 0) ? 4'($urandom) : '0;
      ib.clr = ($urandom_range(0, 29) == 0) ? 2'($urandom) : '0;
      if ($urandom_range(0, 699) == 0) begin
        enter_reset();
        tick();
        rst = 1'b0;
      end
      tick();
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
